// File: rtl/versat_delay_reg_bank.sv
// N-channel delayed capture/accumulate register bank with a shared memory-mapped port.
// Each channel starts on run, waits its delay, then samples its input once or over a burst.
module versat_delay_reg_bank #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 32,
    parameter int DELAY_W = 16,
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    output logic                     done,
    input  logic [N_CH*DATA_W-1:0]   in_flat,
    input  logic [N_CH*DELAY_W-1:0]  delay_flat,
    input  logic [N_CH-1:0]          mode,
    input  logic [ACC_W-1:0]         acc_len,
    output logic [N_CH*DATA_W-1:0]   currentValue_flat,
    input  logic                     valid,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     ready,
    output logic [DATA_W-1:0]        rdata
);

    // state  | meaning
    // IDLE   | never started since reset
    // WAIT   | counting down delay; samples its first value when dcnt reaches 0
    // SAMPLE | accumulating further samples of a burst
    // FIN    | holding result until the next run
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FIN} state_t;

    state_t             state     [N_CH];
    state_t             state_nxt [N_CH];
    logic [DELAY_W-1:0] dcnt      [N_CH];
    logic [DELAY_W-1:0] dcnt_nxt  [N_CH];
    logic [ACC_W-1:0]   scnt      [N_CH];
    logic [ACC_W-1:0]   scnt_nxt  [N_CH];
    logic [DATA_W-1:0]  regs      [N_CH];
    logic [DATA_W-1:0]  regs_nxt  [N_CH];
    logic [N_CH-1:0]    sample_now;
    logic               all_quiet;
    logic               bus_wr;
    logic [DATA_W-1:0]  rd_val;
    logic [ACC_W-1:0]   burst_len;

    assign bus_wr    = valid && (wstrb != '0);
    assign burst_len = (acc_len == '0) ? ACC_W'(1) : acc_len;

    always_comb begin
        all_quiet  = 1'b1;
        sample_now = '0;
        rd_val     = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = state[i];
            dcnt_nxt[i]  = dcnt[i];
            scnt_nxt[i]  = scnt[i];
            regs_nxt[i]  = regs[i];
            case (state[i])
                WAIT: begin
                    if (dcnt[i] == '0) begin
                        sample_now[i] = 1'b1;
                        regs_nxt[i]   = in_flat[i*DATA_W +: DATA_W];
                        scnt_nxt[i]   = scnt[i] - ACC_W'(1);
                        state_nxt[i]  = (scnt[i] <= ACC_W'(1)) ? FIN : SAMPLE;
                    end else begin
                        dcnt_nxt[i] = dcnt[i] - DELAY_W'(1);
                    end
                end
                SAMPLE: begin
                    sample_now[i] = 1'b1;
                    regs_nxt[i]   = regs[i] + in_flat[i*DATA_W +: DATA_W];
                    scnt_nxt[i]   = scnt[i] - ACC_W'(1);
                    state_nxt[i]  = (scnt[i] <= ACC_W'(1)) ? FIN : SAMPLE;
                end
                default: ;
            endcase
            // A sample on this edge takes priority over a bus write to the same channel.
            if (bus_wr && !sample_now[i] && addr == ADDR_W'(i)) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (wstrb[b]) regs_nxt[i][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
            if (run) begin
                state_nxt[i] = WAIT;
                dcnt_nxt[i]  = delay_flat[i*DELAY_W +: DELAY_W];
                scnt_nxt[i]  = mode[i] ? burst_len : ACC_W'(1);
            end
            if (state_nxt[i] == WAIT || state_nxt[i] == SAMPLE) all_quiet = 1'b0;
            if (addr == ADDR_W'(i)) rd_val = regs[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= IDLE;
                dcnt[i]  <= '0;
                scnt[i]  <= '0;
                regs[i]  <= '0;
            end
            done  <= 1'b1;
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state[i] <= state_nxt[i];
                dcnt[i]  <= dcnt_nxt[i];
                scnt[i]  <= scnt_nxt[i];
                regs[i]  <= regs_nxt[i];
            end
            done  <= all_quiet;
            ready <= valid;
            rdata <= (valid && wstrb == '0) ? rd_val : '0;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cur
        assign currentValue_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
